// File: rtl/vga_pkg.sv
// Shared timing defaults, sync polarity, scan-control records and colour-word
// layout helpers for the framebuffer scan-out pipeline.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } sync_pol_e;

  function automatic int scan_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = scan_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = scan_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Colour words are packed {B,G,R}, R in the low field.
  localparam int R_FIELD = 0;
  localparam int G_FIELD = 1;
  localparam int B_FIELD = 2;

  function automatic int color_word_w(input int cw);
    return 3 * cw;
  endfunction

  function automatic int field_lsb(input int field, input int cw);
    return field * cw;
  endfunction

  // Raster flags produced at the read stage and carried to the pins.
  typedef struct packed {
    logic blank_n;
    logic hs;
    logic vs;
    logic fs;
  } sync_ctl_t;

  // Per-pixel frame settings needed at the colour-select stage.
  typedef struct packed {
    logic en;
    logic mode;
  } pix_ctl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with active-region, sync-window,
// frame-boundary and first-pixel flags, all decoded for the current cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst,
  output logic active,
  output logic hs,
  output logic vs,
  output logic boundary,
  output logic first_px
);

  localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs       = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
  assign vs       = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
  assign boundary = rst || (h_last && v_last);
  assign first_px = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_scanout_pipe.sv
// Framebuffer scan-out: per-frame latched base/mode/enable, read addressing,
// direct or palette colour path and sync flags delayed to a common latency.
module vga_scanout_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 8,
  parameter int IDX_W    = 8,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 1,
  parameter int PAL_LAT  = 1
) (
  input  logic                   iVGA_CLK,
  input  logic                   iRST,
  input  logic                   iEN,
  input  logic                   iMODE,
  input  logic [ADDR_W-1:0]      iBASE,
  output logic                   oRD_EN,
  output logic [ADDR_W-1:0]      oRD_ADDR,
  input  logic [3*COLOR_W-1:0]   iRD_DATA,
  output logic [IDX_W-1:0]       oPAL_ADDR,
  input  logic [3*COLOR_W-1:0]   iPAL_DATA,
  output logic                   oBLANK_n,
  output logic                   oHS,
  output logic                   oVS,
  output logic [COLOR_W-1:0]     oR,
  output logic [COLOR_W-1:0]     oG,
  output logic [COLOR_W-1:0]     oB,
  output logic                   oFRAME_START
);

  localparam int        L     = RD_LAT + PAL_LAT + 1;
  localparam int        CW    = color_word_w(COLOR_W);
  localparam int        R_LSB = field_lsb(R_FIELD, COLOR_W);
  localparam int        G_LSB = field_lsb(G_FIELD, COLOR_W);
  localparam int        B_LSB = field_lsb(B_FIELD, COLOR_W);
  localparam sync_pol_e HS_P  = (HS_POL != 0) ? POL_HIGH : POL_LOW;
  localparam sync_pol_e VS_P  = (VS_POL != 0) ? POL_HIGH : POL_LOW;

  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("vga_scanout_pipe: RD_LAT must be >= 1");
  end
  if (PAL_LAT < 1) begin : g_bad_pal_lat
    $error("vga_scanout_pipe: PAL_LAT must be >= 1");
  end
  if (IDX_W > CW) begin : g_bad_idx_w
    $error("vga_scanout_pipe: IDX_W must not exceed 3*COLOR_W");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_scanout_pipe: sync and porch widths must be >= 1");
  end

  logic active;
  logic hs_act;
  logic vs_act;
  logic boundary;
  logic first_px;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk      (iVGA_CLK),
    .rst      (iRST),
    .active   (active),
    .hs       (hs_act),
    .vs       (vs_act),
    .boundary (boundary),
    .first_px (first_px)
  );

  logic              en_q;
  logic              mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_active;

  assign rd_active = active && en_q;

  // Reset counts as a frame boundary, so settings are captured from the inputs.
  always_ff @(posedge iVGA_CLK) begin
    if (boundary) begin
      en_q   <= iEN;
      mode_q <= iMODE;
      addr_q <= iBASE;
    end else if (rd_active) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Read port is held quiet for as long as reset is asserted.
  assign oRD_EN    = rd_active && !iRST;
  assign oRD_ADDR  = iRST ? '0 : addr_q;
  assign oPAL_ADDR = iRD_DATA[IDX_W-1:0];

  sync_ctl_t             sync0;
  pix_ctl_t              pix0;
  sync_ctl_t [L-1:0]     sync_pipe;
  pix_ctl_t  [L-2:0]     pix_pipe;

  always_comb begin
    sync0         = '0;
    sync0.blank_n = active;
    sync0.hs      = hs_act;
    sync0.vs      = vs_act;
    sync0.fs      = first_px;
    pix0          = '0;
    pix0.en       = en_q;
    pix0.mode     = mode_q;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      sync_pipe <= '0;
      pix_pipe  <= '0;
    end else begin
      sync_pipe <= {sync_pipe[L-2:0], sync0};
      pix_pipe  <= {pix_pipe[L-3:0], pix0};
    end
  end

  // Direct data is padded by PAL_LAT stages so both modes share one latency.
  logic [PAL_LAT-1:0][CW-1:0] dir_pipe;

  if (PAL_LAT == 1) begin : g_dir_one
    always_ff @(posedge iVGA_CLK) begin
      if (iRST) dir_pipe <= '0;
      else      dir_pipe <= iRD_DATA;
    end
  end else begin : g_dir_many
    always_ff @(posedge iVGA_CLK) begin
      if (iRST) dir_pipe <= '0;
      else      dir_pipe <= {dir_pipe[PAL_LAT-2:0], iRD_DATA};
    end
  end

  sync_ctl_t       sel_sync;
  pix_ctl_t        sel_pix;
  sync_ctl_t       out_sync;
  logic [CW-1:0]   colour_q;

  assign sel_sync = sync_pipe[L-2];
  assign sel_pix  = pix_pipe[L-2];
  assign out_sync = sync_pipe[L-1];

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      colour_q <= '0;
    end else if (sel_sync.blank_n && sel_pix.en) begin
      colour_q <= sel_pix.mode ? iPAL_DATA : dir_pipe[PAL_LAT-1];
    end else begin
      colour_q <= '0;
    end
  end

  assign oBLANK_n     = out_sync.blank_n;
  assign oHS          = (HS_P == POL_HIGH) ? out_sync.hs : !out_sync.hs;
  assign oVS          = (VS_P == POL_HIGH) ? out_sync.vs : !out_sync.vs;
  assign oFRAME_START = out_sync.fs;
  assign oR           = colour_q[R_LSB +: COLOR_W];
  assign oG           = colour_q[G_LSB +: COLOR_W];
  assign oB           = colour_q[B_LSB +: COLOR_W];

endmodule
